// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter unit.
// Cond encodings, FSM states and default vectors live here.
package pc_pkg;

    localparam logic [1:0] COND_SEQ  = 2'b00;
    localparam logic [1:0] COND_BR   = 2'b01;
    localparam logic [1:0] COND_RET  = 2'b10;
    localparam logic [1:0] COND_JALR = 2'b11;

    typedef enum logic [1:0] {
        BOOT = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } pc_state_t;

    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0100;

    // Sequential targets are never alignment-checked.
    function automatic logic cond_checked(input logic [1:0] c);
        return c != COND_SEQ;
    endfunction

endpackage

// File: rtl/pc_align_chk.sv
// Target alignment check: bit 0 with C extension, bits 1:0 otherwise.
module pc_align_chk #(
    parameter int XLEN  = 32,
    parameter bit C_EXT = 1'b0
) (
    input  logic [XLEN-1:0] target,
    output logic            misaligned
);

    logic unused_hi;
    assign unused_hi = ^target[XLEN-1:2];

    assign misaligned = C_EXT ? target[0] : (target[1:0] != 2'b00);

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: target select, PC/EPC/badaddr registers and
// the BOOT/RUN/HALT control FSM for the single-stage core.
module pc_unit
    import pc_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEF_RESET_VEC),
    parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(DEF_TRAP_VEC),
    parameter bit              C_EXT     = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] alu_out,
    input  logic [1:0]      cond,
    input  logic            stall,
    input  logic            halt_req,
    input  logic            resume,
    input  logic            trap_req,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] normal_pc,
    output logic [XLEN-1:0] jal_branch_pc,
    output logic [XLEN-1:0] epc,
    output logic [XLEN-1:0] badaddr,
    output logic            misalign_exc,
    output logic            fetch_valid,
    output logic            halted
);

    pc_state_t       state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] epc_q;
    logic [XLEN-1:0] badaddr_q;
    logic            misalign_q;
    logic            fetch_valid_q;
    logic            halted_q;

    logic [XLEN-1:0] target;
    logic            tgt_misaligned;
    logic            bad_target;

    assign normal_pc     = pc_q + XLEN'(4);
    assign jal_branch_pc = pc_q + imm;

    always_comb begin
        target = normal_pc;
        unique case (cond)
            COND_SEQ:  target = normal_pc;
            COND_BR:   target = jal_branch_pc;
            COND_JALR: target = {alu_out[XLEN-1:1], 1'b0};
            COND_RET:  target = epc_q;
            default:   target = normal_pc;
        endcase
    end

    pc_align_chk #(
        .XLEN  (XLEN),
        .C_EXT (C_EXT)
    ) u_align (
        .target     (target),
        .misaligned (tgt_misaligned)
    );

    assign bad_target = tgt_misaligned && cond_checked(cond);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= BOOT;
            pc_q          <= RESET_VEC;
            epc_q         <= '0;
            badaddr_q     <= '0;
            misalign_q    <= 1'b0;
            fetch_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            unique case (state_q)
                BOOT: begin
                    state_q       <= RUN;
                    fetch_valid_q <= 1'b1;
                end
                RUN: begin
                    if (!stall) begin
                        if (trap_req) begin
                            epc_q <= pc_q;
                            pc_q  <= TRAP_VEC;
                        end else if (bad_target) begin
                            epc_q      <= pc_q;
                            badaddr_q  <= target;
                            pc_q       <= TRAP_VEC;
                            misalign_q <= 1'b1;
                        end else begin
                            pc_q <= target;
                        end
                        // The instruction in flight still retires.
                        if (halt_req) begin
                            state_q       <= HALT;
                            fetch_valid_q <= 1'b0;
                            halted_q      <= 1'b1;
                        end
                    end
                end
                HALT: begin
                    if (resume) begin
                        state_q       <= RUN;
                        fetch_valid_q <= 1'b1;
                        halted_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q       <= BOOT;
                    fetch_valid_q <= 1'b0;
                    halted_q      <= 1'b0;
                end
            endcase
        end
    end

    assign pc           = pc_q;
    assign epc          = epc_q;
    assign badaddr      = badaddr_q;
    assign misalign_exc = misalign_q;
    assign fetch_valid  = fetch_valid_q;
    assign halted       = halted_q;

endmodule
